pix_serial_framer: RTL and testbench

- Downstream consumer of the capture stage's 12-bit pixel words and write-complete strobe.
- Buffers pixels in a small FIFO and tags the first pixel after each VSYNC rising edge as a frame marker.
- Shifts each pixel out on a single asynchronous-style serial line: start bit, 12 data bits, marker bit, stop bit.
- Replaces the externally clocked serial path; the line rate is generated internally from clk.

---
 rtl/pix_serial_framer.sv | 135 +++++++++++++
 tb/tb_pix_serial_framer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pix_serial_framer.sv
// Pixel FIFO plus UART-style serializer: start, 12 data bits LSB first, frame marker, stop.
// The first pixel written after each vsync rising edge carries marker=1.
//
// state | meaning
// IDLE  | line high, pops the FIFO head into the shift register when data is waiting
// SHIFT | line driven from the shift register, one bit per BAUD_DIV clk cycles
module pix_serial_framer #(
  parameter int DEPTH    = 16,
  parameter int BAUD_DIV = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   vsync,
  input  logic                   pix_wr,
  input  logic [11:0]            pix_data,
  output logic                   ser_out,
  output logic                   busy,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BAUD_TC    = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    LAST_BIT   = 4'd14;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          vsync_d, marker_pending;
  logic          vsync_rise, pop, wr_ok;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [3:0]    bit_idx, bit_nxt;
  logic [14:0]   shreg, shreg_nxt;
  logic          ser_nxt, busy_nxt;

  assign vsync_rise = vsync & ~vsync_d;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign wr_ok = pix_wr & ((fifo_level != LEVEL_FULL) | pop);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    ser_nxt   = ser_out;
    busy_nxt  = busy;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        ser_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (fifo_level != '0) begin
          pop       = 1'b1;
          shreg_nxt = {1'b1, mem[rd_ptr], 1'b0};
          ser_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy_nxt = 1'b1;
        if (baud_cnt == BAUD_TC) begin
          baud_nxt = '0;
          if (bit_idx == LAST_BIT) begin
            state_nxt = IDLE;
            ser_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            bit_nxt   = '0;
          end else begin
            bit_nxt   = bit_idx + 4'd1;
            shreg_nxt = {1'b1, shreg[14:1]};
            ser_nxt   = shreg[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      ser_out  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= shreg_nxt;
      ser_out  <= ser_nxt;
      busy     <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {marker_pending | vsync_rise, pix_data};
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      vsync_d        <= 1'b0;
      marker_pending <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (vsync_rise)  marker_pending <= 1'b1;
      else if (wr_ok)  marker_pending <= 1'b0;
      // A drop in the same cycle as a vsync edge leaves the flag set.
      if (pix_wr && !wr_ok) ovf <= 1'b1;
      else if (vsync_rise)  ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pix_serial_framer.sv
// Bench for pix_serial_framer: directed writes feed an expected-frame queue,
// a line monitor decodes each serial frame and compares against the queue head.
module tb_pix_serial_framer;

  localparam int DEPTH = 16;
  localparam int BD    = 4;
  localparam int FL    = 15 * BD;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        vsync = 1'b0;
  logic        pix_wr = 1'b0;
  logic [11:0] pix_data = '0;
  logic        ser_out, busy, ovf;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_abort = 0;
  logic [12:0] exp_q[$];
  int starts_q[$];

  pix_serial_framer #(.DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
    .clk(clk), .nrst(nrst), .vsync(vsync), .pix_wr(pix_wr), .pix_data(pix_data),
    .ser_out(ser_out), .busy(busy), .ovf(ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] d, input logic mk);
    @(negedge clk);
    pix_wr = 1'b1;
    pix_data = d;
    exp_q.push_back({mk, d});
    @(negedge clk);
    pix_wr = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || fifo_level !== 5'd0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", (t < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: captures every cycle of a frame, so bit hold time is checked too.
  initial begin
    logic [14:0] got;
    logic        hold_bad, aborted;
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1 && ser_out === 1'b0) begin
        starts_q.push_back(cyc);
        hold_bad = 1'b0;
        aborted  = 1'b0;
        got      = '0;
        for (int k = 0; k < 15 && !aborted; k++) begin
          for (int j = 0; j < BD && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (busy !== 1'b1) aborted = 1'b1;
            else if (j == 0) got[k] = ser_out;
            else if (ser_out !== got[k]) hold_bad = 1'b1;
          end
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n_abort++;
        end else begin
          @(negedge clk);
          chk("gap_idle_busy_ser", {busy, ser_out}, 2'b01);
          if (exp_q.size() > 0) e = exp_q.pop_front();
          else e = 'x;
          chk("frame_bits", got, {1'b1, e, 1'b0});
          chk("bit_hold", hold_bad, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int bad, t, diff;
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser_out !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0 || ovf !== 1'b0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Single word 0xA5C, no marker.
    wr(12'hA5C, 1'b0);
    chk("single_level_n1", fifo_level, 1);
    @(negedge clk);
    chk("single_level_n2", fifo_level, 0);
    chk("single_start_n2", ser_out, 0);
    chk("single_busy_n2", busy, 1);
    wait_drain();

    // Marker on first word after vsync rise; vsync held high gives no second marker.
    starts_q.delete();
    @(negedge clk);
    vsync = 1'b1;
    wr(12'h001, 1'b1);
    wr(12'h002, 1'b0);
    wait_drain();
    chk("two_frames_seen", starts_q.size(), 2);
    diff = (starts_q.size() >= 2) ? starts_q[1] - starts_q[0] : 0;
    chk("back_to_back_spacing", diff, FL + 1);
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);

    // 20 back-to-back writes: word 0 pops at once, words 1..16 fill, 17..19 drop.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_wr = 1'b1;
      pix_data = 12'h100 + 12'(i);
      if (i <= 16) exp_q.push_back({1'b0, 12'h100 + 12'(i)});
    end
    @(negedge clk);
    pix_wr = 1'b0;
    chk("ovf_level_full", fifo_level, 16);
    chk("ovf_set", ovf, 1);
    vsync = 1'b1;
    @(negedge clk);
    chk("ovf_cleared_by_vsync", ovf, 0);
    chk("level_still_full", fifo_level, 16);

    // Write during the IDLE pop cycle of a full FIFO; the pending marker lands here.
    t = 0;
    while (busy === 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_cycle_found", busy, 0);
    chk("full_before_pop", fifo_level, 16);
    pix_wr = 1'b1;
    pix_data = 12'h7E7;
    exp_q.push_back({1'b1, 12'h7E7});
    @(negedge clk);
    pix_wr = 1'b0;
    vsync = 1'b0;
    chk("full_pop_write_level", fifo_level, 16);
    chk("full_pop_write_ovf", ovf, 0);
    wait_drain();

    // Reset during bit 7 of a frame.
    wr(12'h3C3, 1'b0);
    repeat (30) @(negedge clk);
    chk("busy_at_bit7", busy, 1);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_ser_out", ser_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("aborted_frames", n_abort, 1);
    wr(12'h5A5, 1'b0);
    wait_drain();
    chk("ovf_final", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
